// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: expands one 512-bit block into W0..W63 and streams
// each word with its round constant and index over a valid/ready handshake.
module sha256_msg_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_out,
    output logic [31:0]  k_out,
    output logic [5:0]   round,
    output logic         w_last
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  t_q, t_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            win_q   <= win_d;
        end
    end

    // Sliding 16-word window: win_q[0] is always W_t, the new tail is W_{t+16}.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        win_d   = win_q;
        case (state_q)
            IDLE: begin
                if (blk_valid) begin
                    for (int unsigned i = 0; i < 16; i++) begin
                        win_d[i] = blk_data[32*(15-i) +: 32];
                    end
                    t_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (w_ready) begin
                    for (int unsigned i = 0; i < 15; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    win_d[15] = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
                    t_d       = t_q + 6'd1;
                    if (t_q == 6'd63) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        blk_ready = (state_q == IDLE);
        w_valid   = (state_q == RUN);
        w_out     = w_valid ? win_q[0] : '0;
        k_out     = w_valid ? K_ROM[t_q] : '0;
        round     = w_valid ? t_q : '0;
        w_last    = w_valid && (t_q == 6'd63);
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule against a FIPS 180-4 style
// whole-array schedule model with randomized blocks and backpressure.
module tb_sha256_msg_schedule;

    logic         clk;
    logic         rst;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_out;
    logic [31:0]  k_out;
    logic [5:0]   round;
    logic         w_last;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [31:0] exp_w [64];
    logic [31:0] obs_w [64];
    logic [31:0] obs_k [64];
    logic [5:0]  obs_r [64];
    logic        obs_l [64];
    int unsigned nbeats;

    logic [511:0] abc_blk;

    logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    sha256_msg_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_out     (w_out),
        .k_out     (k_out),
        .round     (round),
        .w_last    (w_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Direct recurrence over the whole 64-entry array.
    task automatic compute_model(input logic [511:0] b);
        for (int i = 0; i < 16; i++) exp_w[i] = b[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            exp_w[i] = ssig1(exp_w[i-2]) + exp_w[i-7] + ssig0(exp_w[i-15]) + exp_w[i-16];
    endtask

    task automatic rand_block(output logic [511:0] b);
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
    endtask

    // Drive-only: present a block for one edge while in IDLE.
    task automatic load_block(input logic [511:0] b);
        blk_data  = b;
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
    endtask

    // Records accepted beats only; mode 1 randomizes w_ready.
    task automatic capture(input int unsigned mode);
        int unsigned cyc = 0;
        nbeats = 0;
        while (nbeats < 64 && cyc < 1000) begin
            w_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (w_valid && w_ready) begin
                obs_w[nbeats] = w_out;
                obs_k[nbeats] = k_out;
                obs_r[nbeats] = round;
                obs_l[nbeats] = w_last;
                nbeats++;
            end
            @(negedge clk);
            cyc++;
        end
        w_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; blk_valid = 1'b0; w_ready = 1'b0; blk_data = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (w_valid !== 1'b0) begin n_err++; $display("FAIL reset_w_valid: got %b want 0", w_valid); end
        n_cmp++; if (blk_ready !== 1'b1) begin n_err++; $display("FAIL reset_blk_ready: got %b want 1", blk_ready); end
        n_cmp++; if (w_out !== 32'h0) begin n_err++; $display("FAIL reset_w_out: got %h want 0", w_out); end
        n_cmp++; if (round !== 6'd0) begin n_err++; $display("FAIL reset_round: got %0d want 0", round); end
        n_cmp++; if (k_out !== 32'h0 || w_last !== 1'b0) begin n_err++; $display("FAIL reset_k_last: got %h/%b want 0/0", k_out, w_last); end
        rst = 1'b1;
        w_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (w_valid !== 1'b0) begin n_err++; $display("FAIL idle_no_valid: cycle %0d got %b want 0", i, w_valid); end
        end
    endtask

    task automatic test_abc();
        compute_model(abc_blk);
        w_ready = 1'b1;
        load_block(abc_blk);
        n_cmp++; if (w_valid !== 1'b1) begin n_err++; $display("FAIL abc_latency: got %b want 1", w_valid); end
        n_cmp++; if (blk_ready !== 1'b0) begin n_err++; $display("FAIL abc_run_blk_ready: got %b want 0", blk_ready); end
        capture(0);
        n_cmp++; if (nbeats !== 64) begin n_err++; $display("FAIL abc_beats: got %0d want 64", nbeats); end
        for (int t = 0; t < 64; t++) begin
            n_cmp++; if (obs_w[t] !== exp_w[t]) begin n_err++; $display("FAIL abc_w[%0d]: got %h want %h", t, obs_w[t], exp_w[t]); end
            n_cmp++; if (obs_k[t] !== KT[t]) begin n_err++; $display("FAIL abc_k[%0d]: got %h want %h", t, obs_k[t], KT[t]); end
            n_cmp++; if (obs_r[t] !== 6'(t)) begin n_err++; $display("FAIL abc_round[%0d]: got %0d want %0d", t, obs_r[t], t); end
            n_cmp++; if (obs_l[t] !== (t == 63)) begin n_err++; $display("FAIL abc_last[%0d]: got %b want %b", t, obs_l[t], (t == 63)); end
        end
        n_cmp++; if (obs_w[0] !== 32'h61626380) begin n_err++; $display("FAIL abc_W0: got %h want 61626380", obs_w[0]); end
        n_cmp++; if (obs_w[15] !== 32'h00000018) begin n_err++; $display("FAIL abc_W15: got %h want 00000018", obs_w[15]); end
        n_cmp++; if (obs_w[16] !== 32'h61626380) begin n_err++; $display("FAIL abc_W16: got %h want 61626380", obs_w[16]); end
        n_cmp++; if (obs_w[17] !== 32'h000f0000) begin n_err++; $display("FAIL abc_W17: got %h want 000f0000", obs_w[17]); end
        n_cmp++; if (obs_w[63] !== 32'h12b1edeb) begin n_err++; $display("FAIL abc_W63: got %h want 12b1edeb", obs_w[63]); end
        n_cmp++; if (obs_k[63] !== 32'hc67178f2) begin n_err++; $display("FAIL abc_K63: got %h want c67178f2", obs_k[63]); end
        n_cmp++; if (blk_ready !== 1'b1 || w_valid !== 1'b0) begin n_err++; $display("FAIL abc_after: got rdy=%b vld=%b want 1/0", blk_ready, w_valid); end
        n_cmp++; if (w_out !== 32'h0 || round !== 6'd0) begin n_err++; $display("FAIL abc_gated: got %h/%0d want 0/0", w_out, round); end
    endtask

    task automatic test_stall();
        int unsigned idx = 0, stalled = 0, cyc = 0;
        compute_model(abc_blk);
        w_ready = 1'b1;
        load_block(abc_blk);
        while (idx < 64 && cyc < 300) begin
            n_cmp++; if (w_valid !== 1'b1 || w_out !== exp_w[idx]) begin n_err++; $display("FAIL stall_w[%0d]: got vld=%b %h want 1 %h", idx, w_valid, w_out, exp_w[idx]); end
            n_cmp++; if (round !== 6'(idx)) begin n_err++; $display("FAIL stall_round: got %0d want %0d", round, idx); end
            if (idx == 63) begin
                n_cmp++; if (w_out !== 32'h12b1edeb) begin n_err++; $display("FAIL stall_W63: got %h want 12b1edeb", w_out); end
            end
            if (round == 6'd16 && stalled < 3) begin
                w_ready = 1'b0;
                stalled++;
            end else begin
                w_ready = 1'b1;
            end
            if (w_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (idx !== 64 || stalled !== 3) begin n_err++; $display("FAIL stall_progress: got %0d/%0d want 64/3", idx, stalled); end
        n_cmp++; if (w_valid !== 1'b0 || blk_ready !== 1'b1) begin n_err++; $display("FAIL stall_end: got vld=%b rdy=%b want 0/1", w_valid, blk_ready); end
    endtask

    task automatic test_random();
        logic [511:0] b;
        for (int n = 0; n < 4; n++) begin
            rand_block(b);
            compute_model(b);
            load_block(b);
            capture(1);
            n_cmp++; if (nbeats !== 64) begin n_err++; $display("FAIL rnd%0d_beats: got %0d want 64", n, nbeats); end
            for (int t = 0; t < 64; t++) begin
                n_cmp++;
                if (obs_w[t] !== exp_w[t] || obs_k[t] !== KT[t] || obs_r[t] !== 6'(t) || obs_l[t] !== (t == 63)) begin
                    n_err++;
                    $display("FAIL rnd%0d_beat[%0d]: got %h %h %0d %b want %h %h %0d %b", n, t,
                             obs_w[t], obs_k[t], obs_r[t], obs_l[t], exp_w[t], KT[t], t, (t == 63));
                end
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_block_during_run();
        logic [511:0] b;
        int unsigned idx = 0, cyc = 0;
        rand_block(b);
        compute_model(abc_blk);
        w_ready = 1'b1;
        load_block(abc_blk);
        while (idx < 64 && cyc < 300) begin
            n_cmp++; if (w_out !== exp_w[idx] || round !== 6'(idx)) begin n_err++; $display("FAIL bdr_w[%0d]: got %h r%0d want %h", idx, w_out, round, exp_w[idx]); end
            if (blk_valid) begin
                n_cmp++; if (blk_ready !== 1'b0) begin n_err++; $display("FAIL bdr_blk_ready: got %b want 0", blk_ready); end
            end
            if (round == 6'd5) begin
                blk_data  = b;
                blk_valid = 1'b1;
            end
            idx++;
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (idx !== 64) begin n_err++; $display("FAIL bdr_progress: got %0d want 64", idx); end
        n_cmp++; if (blk_ready !== 1'b1 || w_valid !== 1'b0) begin n_err++; $display("FAIL bdr_idle: got rdy=%b vld=%b want 1/0", blk_ready, w_valid); end
        @(negedge clk);
        blk_valid = 1'b0;
        compute_model(b);
        n_cmp++; if (w_valid !== 1'b1 || round !== 6'd0 || w_out !== exp_w[0]) begin n_err++; $display("FAIL bdr_next_W0: got vld=%b r%0d %h want 1 r0 %h", w_valid, round, w_out, exp_w[0]); end
        capture(0);
        n_cmp++; if (nbeats !== 64) begin n_err++; $display("FAIL bdr_beats: got %0d want 64", nbeats); end
        for (int t = 0; t < 64; t++) begin
            n_cmp++; if (obs_w[t] !== exp_w[t] || obs_r[t] !== 6'(t)) begin n_err++; $display("FAIL bdr2_w[%0d]: got %h r%0d want %h", t, obs_w[t], obs_r[t], exp_w[t]); end
        end
    endtask

    task automatic test_back_to_back();
        int unsigned beats = 0, gap = 0, cyc = 0;
        logic [31:0] w63a = '0, w63b = '0;
        compute_model(abc_blk);
        w_ready   = 1'b1;
        blk_data  = abc_blk;
        blk_valid = 1'b1;
        @(negedge clk);
        while (beats < 128 && cyc < 400) begin
            if (w_valid) begin
                n_cmp++; if (w_out !== exp_w[beats % 64] || round !== 6'(beats % 64)) begin n_err++; $display("FAIL b2b_beat[%0d]: got %h r%0d want %h", beats, w_out, round, exp_w[beats % 64]); end
                if (beats == 63) w63a = w_out;
                if (beats == 127) w63b = w_out;
                if (beats >= 64) blk_valid = 1'b0;
                beats++;
            end else if (beats > 0) begin
                gap++;
            end
            if (beats < 128) begin
                @(negedge clk);
                cyc++;
            end
        end
        blk_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (beats !== 128) begin n_err++; $display("FAIL b2b_beats: got %0d want 128", beats); end
        n_cmp++; if (gap !== 1) begin n_err++; $display("FAIL b2b_gap: got %0d want 1", gap); end
        n_cmp++; if (w63a !== 32'h12b1edeb || w63b !== 32'h12b1edeb) begin n_err++; $display("FAIL b2b_W63: got %h %h want 12b1edeb", w63a, w63b); end
        n_cmp++; if (w_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end: got %b want 0", w_valid); end
    endtask

    task automatic test_reset_mid_run();
        logic [511:0] b;
        int unsigned cyc = 0;
        w_ready = 1'b1;
        load_block(abc_blk);
        while (round != 6'd30 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (round !== 6'd30) begin n_err++; $display("FAIL mid_reach30: got %0d want 30", round); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (w_valid !== 1'b0 || blk_ready !== 1'b1) begin n_err++; $display("FAIL mid_async: got vld=%b rdy=%b want 0/1", w_valid, blk_ready); end
        n_cmp++; if (w_out !== 32'h0 || k_out !== 32'h0 || round !== 6'd0 || w_last !== 1'b0) begin n_err++; $display("FAIL mid_outs: got %h %h %0d %b want 0", w_out, k_out, round, w_last); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (w_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_resume: got %b want 0", w_valid); end
        rand_block(b);
        compute_model(b);
        load_block(b);
        capture(0);
        n_cmp++; if (nbeats !== 64) begin n_err++; $display("FAIL mid_beats: got %0d want 64", nbeats); end
        for (int t = 0; t < 64; t++) begin
            n_cmp++; if (obs_w[t] !== exp_w[t] || obs_r[t] !== 6'(t)) begin n_err++; $display("FAIL mid_w[%0d]: got %h r%0d want %h", t, obs_w[t], obs_r[t], exp_w[t]); end
        end
    endtask

    initial begin
        abc_blk = {32'h61626380, 448'b0, 32'h00000018};
        test_reset();
        test_abc();
        test_stall();
        test_random();
        test_block_during_run();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
- Upstream neighbour of the SHA-256 compression round (main_loop).
- Accepts one 512-bit padded message block and expands it into the 64-word schedule W0..W63.
- Issues one word per accepted beat, paired with its round constant K_t and the round index, over a valid/ready handshake.
- The round stage consumes w_out/k_out directly as its w/k operands.

Parameters:
- none; widths are fixed by SHA-256: 32-bit words, 64 rounds, 512-bit block.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- blk_valid  input  1  blk_data holds a block
- blk_ready  output  1  schedule can take a block (state IDLE)
- blk_data  input  512  message block, word 0 = blk_data[511:480], word 15 = blk_data[31:0] (big-endian word order)
- w_valid  output  1  w_out/k_out/round valid
- w_ready  input  1  round stage accepts current word
- w_out  output  32  schedule word W_t
- k_out  output  32  round constant K_t (FIPS 180-4)
- round  output  6  t, 0..63
- w_last  output  1  high with round==63 while w_valid

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; 16-word window cleared; t=0.
  - Outputs: w_valid=0, w_out=0, k_out=0, round=0, w_last=0, blk_ready=1.
- State machine, two states:
  - IDLE: blk_ready=1, w_valid=0.
    - blk_valid&&blk_ready at an edge loads window[i]=word i for i=0..15, sets t=0 and moves to RUN.
  - RUN: blk_ready=0, w_valid=1.
    - Outputs: w_out=window[0], k_out=K[t], round=t, w_last=(t==63).
- Latency: first word valid the cycle after block acceptance. No bubbles while w_ready stays high, so 64 words in 64 consecutive cycles.
- Accept rule: a beat is consumed only when w_valid&&w_ready.
  - On accept: window shifts down (window[i]<=window[i+1]), t<=t+1.
  - New window[15] <= sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0], all additions mod 2^32 with the carry discarded.
  - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Stall: while w_ready=0 in RUN, all outputs and internal state hold unchanged for any number of cycles.
- Final beat: accept at t=63 returns to IDLE. Next cycle w_valid=0 and blk_ready=1; t wraps to 0 and the window contents are don't-care.
  - Words computed for t>=48 are never output; this is harmless.
- Block presented during RUN: ignored (blk_ready=0); the upstream holds blk_valid and blk_data stable until the handshake.
- Back-to-back blocks: a block can be accepted the cycle after the last beat. Minimum block period is 65 cycles.
- Outputs are gated: w_out, k_out, round and w_last read 0 whenever w_valid=0.
- Reset mid-operation: asserting rst during RUN aborts immediately to reset values. A partially issued block is discarded and never resumed.
- K table: 64-entry constant ROM indexed by t, K[0]=0x428a2f98 ... K[63]=0xc67178f2.
- All state is clocked on posedge clk with async clear on negedge rst. The K lookup and sigma logic are combinational.

Test Plan:
- Reset: rst=0 then release -> w_valid=0, blk_ready=1, w_out=0, round=0; no w_valid before a block arrives.
- "abc" block, w_ready held 1:
  - Block: word0=0x61626380, words1..14=0, word15=0x00000018.
  - Required: w_valid 1 cycle after accept; W0=0x61626380 with K=0x428a2f98; W15=0x00000018; W16=0x61626380; W17=0x000f0000.
  - Required: W63=0x12b1edeb with k_out=0xc67178f2, round=63, w_last=1; blk_ready=1 next cycle.
- Stall: same block, drop w_ready for 3 cycles at round=16 -> w_out stays 0x61626380 and round stays 16 throughout; sequence resumes unchanged; W63 still 0x12b1edeb.
- Block during RUN: assert blk_valid with a different block at round=5 -> blk_ready=0, schedule unaffected. After round 63 is accepted, the pending block is taken the next cycle and its W0 appears one cycle later.
- Back-to-back: two identical "abc" blocks with w_ready=1 -> 128 valid beats with exactly one idle cycle between round 63 and the next round 0; both W63=0x12b1edeb.
- Reset mid-run: rst=0 at round=30 -> w_valid=0 and outputs 0 immediately (asynchronous). After release, a fresh block restarts at round=0 with the correct W0.
